fila_ram_ctrl: RTL and testbench

- FIFO controller placed directly upstream of the 8-bit dual-address RAM (mem_ram); it owns the write and read pointers and drives all of the RAM's address, data and write-enable inputs.
- Gives the processor datapath a queue interface with full/empty flags and a fixed-latency, valid-tagged read return.
- The RAM serves only as storage; all sequencing lives in this block.

---
 rtl/fila_ram_ctrl_pkg.sv | 11 +
 rtl/fila_ponteiro.sv | 30 +++
 rtl/fila_ram_ctrl.sv | 158 +++++++++++++++
 tb/tb_fila_ram_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fila_ram_ctrl_pkg.sv
// Shared constants for every block that talks to the 8-bit dual-address RAM (mem_ram).
//   LARGURA_DADO    : RAM word width
//   LARGURA_END     : RAM address width
//   LAT_LEITURA_RAM : cycles from the read-address register to usable ram_saida
package fila_ram_ctrl_pkg;

  localparam int unsigned LARGURA_DADO    = 8;
  localparam int unsigned LARGURA_END     = 7;
  localparam int unsigned LAT_LEITURA_RAM = 2;

endpackage

// File: rtl/fila_ponteiro.sv
// Modulo-PROFUNDIDADE incrementing pointer, used for both the write and the read side.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer clears to 0)
//   i_en       : advance by one on the rising edge
//   o_ptr      : current pointer value, registered
module fila_ponteiro #(
  parameter int unsigned PROFUNDIDADE = 32,
  parameter int unsigned LARGURA_PTR  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  output logic [LARGURA_PTR-1:0] o_ptr
);

  logic [LARGURA_PTR-1:0] r_ptr;

  // Explicit wrap so depths that are not a power of two work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      if (r_ptr == LARGURA_PTR'(PROFUNDIDADE - 1)) r_ptr <= '0;
      else                                         r_ptr <= r_ptr + LARGURA_PTR'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fila_ram_ctrl.sv
// FIFO controller in front of mem_ram: owns both pointers, drives every RAM input and
// returns dequeued words with a fixed 2-cycle, valid-tagged latency.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   dado_in, wr_en      : enqueue data / request
//   rd_req              : dequeue request
//   dado_out, dado_valido : dequeued word and its one-cycle valid pulse
//   cheia, vazia, nivel : full, empty, occupancy
//   ram_entrada, ram_end_entrada, ram_escrita : RAM write port
//   ram_end_saida, ram_saida                  : RAM read port
// Optional (macro FILA_ERRO_FLAGS_EN): erro_cheia, erro_vazia sticky rejected-request flags.
module fila_ram_ctrl
  import fila_ram_ctrl_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE  = 32,
  parameter int unsigned LARGURA_NIVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LARGURA_DADO-1:0]  dado_in,
  input  logic                     wr_en,
  input  logic                     rd_req,
  output logic [LARGURA_DADO-1:0]  dado_out,
  output logic                     dado_valido,
  output logic                     cheia,
  output logic                     vazia,
  output logic [LARGURA_NIVEL-1:0] nivel,
  output logic [LARGURA_DADO-1:0]  ram_entrada,
  output logic [LARGURA_END-1:0]   ram_end_entrada,
  output logic                     ram_escrita,
  output logic [LARGURA_END-1:0]   ram_end_saida,
  input  logic [LARGURA_DADO-1:0]  ram_saida
`ifdef FILA_ERRO_FLAGS_EN
  ,
  output logic                     erro_cheia,
  output logic                     erro_vazia
`endif
);

  localparam int unsigned LARGURA_PTR = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  logic [LARGURA_PTR-1:0]     w_ptr_esc;
  logic [LARGURA_PTR-1:0]     w_ptr_le;
  logic                       w_esc_ok;
  logic                       w_le_ok;
  logic [LARGURA_NIVEL-1:0]   w_nivel_prox;

  logic [LARGURA_DADO-1:0]    r_dado_out;
  logic                       r_dado_valido;
  logic                       r_cheia;
  logic                       r_vazia;
  logic [LARGURA_NIVEL-1:0]   r_nivel;
  logic [LARGURA_DADO-1:0]    r_ram_entrada;
  logic [LARGURA_END-1:0]     r_ram_end_entrada;
  logic                       r_ram_escrita;
  logic [LARGURA_END-1:0]     r_ram_end_saida;
  logic [LAT_LEITURA_RAM-1:0] r_pipe;

  assign w_esc_ok = wr_en && !r_cheia;
  assign w_le_ok  = rd_req && !r_vazia;

  fila_ponteiro #(.PROFUNDIDADE(PROFUNDIDADE), .LARGURA_PTR(LARGURA_PTR)) u_ptr_esc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_esc_ok),
    .o_ptr (w_ptr_esc)
  );

  fila_ponteiro #(.PROFUNDIDADE(PROFUNDIDADE), .LARGURA_PTR(LARGURA_PTR)) u_ptr_le (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_le_ok),
    .o_ptr (w_ptr_le)
  );

  // Occupancy next-state; simultaneous accepts cancel.
  always_comb begin
    w_nivel_prox = r_nivel;
    case ({w_esc_ok, w_le_ok})
      2'b10:   w_nivel_prox = r_nivel + LARGURA_NIVEL'(1);
      2'b01:   w_nivel_prox = r_nivel - LARGURA_NIVEL'(1);
      default: w_nivel_prox = r_nivel;
    endcase
  end

  // Flags are registered from the next occupancy, so they always equal a decode of nivel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nivel <= '0;
      r_cheia <= 1'b0;
      r_vazia <= 1'b1;
    end else begin
      r_nivel <= w_nivel_prox;
      r_cheia <= (w_nivel_prox == LARGURA_NIVEL'(PROFUNDIDADE));
      r_vazia <= (w_nivel_prox == '0);
    end
  end

  // RAM write port: one-cycle write-enable pulse per accepted enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_escrita     <= 1'b0;
      r_ram_entrada     <= '0;
      r_ram_end_entrada <= '0;
    end else begin
      r_ram_escrita <= w_esc_ok;
      if (w_esc_ok) begin
        r_ram_entrada     <= dado_in;
        r_ram_end_entrada <= LARGURA_END'(w_ptr_esc);
      end
    end
  end

  // RAM read port plus valid pipe matching the RAM's two falling-edge latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_end_saida <= '0;
      r_pipe          <= '0;
      r_dado_valido   <= 1'b0;
      r_dado_out      <= '0;
    end else begin
      if (w_le_ok) r_ram_end_saida <= LARGURA_END'(w_ptr_le);
      r_pipe        <= {r_pipe[LAT_LEITURA_RAM-2:0], w_le_ok};
      r_dado_valido <= r_pipe[LAT_LEITURA_RAM-1];
      if (r_pipe[LAT_LEITURA_RAM-1]) r_dado_out <= ram_saida;
    end
  end

`ifdef FILA_ERRO_FLAGS_EN
  logic r_erro_cheia;
  logic r_erro_vazia;

  // Sticky: only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_erro_cheia <= 1'b0;
      r_erro_vazia <= 1'b0;
    end else begin
      if (wr_en && r_cheia)  r_erro_cheia <= 1'b1;
      if (rd_req && r_vazia) r_erro_vazia <= 1'b1;
    end
  end

  assign erro_cheia = r_erro_cheia;
  assign erro_vazia = r_erro_vazia;
`endif

  assign dado_out        = r_dado_out;
  assign dado_valido     = r_dado_valido;
  assign cheia           = r_cheia;
  assign vazia           = r_vazia;
  assign nivel           = r_nivel;
  assign ram_entrada     = r_ram_entrada;
  assign ram_end_entrada = r_ram_end_entrada;
  assign ram_escrita     = r_ram_escrita;
  assign ram_end_saida   = r_ram_end_saida;

endmodule

// File: tb/tb_fila_ram_ctrl.sv
// Directed self-checking bench for fila_ram_ctrl with a behavioural mem_ram model.
// Optional checks for erro_cheia/erro_vazia are compiled with FILA_ERRO_FLAGS_EN.
module tb_fila_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] dado_in;
  logic       wr_en;
  logic       rd_req;
  logic [7:0] dado_out;
  logic       dado_valido;
  logic       cheia;
  logic       vazia;
  logic [5:0] nivel;
  logic [7:0] ram_entrada;
  logic [6:0] ram_end_entrada;
  logic       ram_escrita;
  logic [6:0] ram_end_saida;
  logic [7:0] ram_saida;
`ifdef FILA_ERRO_FLAGS_EN
  logic       erro_cheia;
  logic       erro_vazia;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fila_ram_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dado_in         (dado_in),
    .wr_en           (wr_en),
    .rd_req          (rd_req),
    .dado_out        (dado_out),
    .dado_valido     (dado_valido),
    .cheia           (cheia),
    .vazia           (vazia),
    .nivel           (nivel),
    .ram_entrada     (ram_entrada),
    .ram_end_entrada (ram_end_entrada),
    .ram_escrita     (ram_escrita),
    .ram_end_saida   (ram_end_saida),
    .ram_saida       (ram_saida)
`ifdef FILA_ERRO_FLAGS_EN
    ,
    .erro_cheia      (erro_cheia),
    .erro_vazia      (erro_vazia)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem_ram model: write commits on rising edge, read address captured on a falling
  // edge and data presented on the following falling edge.
  logic [7:0] mem [0:127];
  logic [6:0] ram_addr_q;
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    ram_addr_q = '0;
    ram_saida  = '0;
  end
  always @(posedge clk) if (ram_escrita) mem[ram_end_entrada] <= ram_entrada;
  always @(negedge clk) begin
    ram_addr_q <= ram_end_saida;
    ram_saida  <= mem[ram_addr_q];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_req = 1'b0; dado_in = '0;
    tick(); tick();
    n_cmp++; if ({vazia, cheia, nivel, dado_valido} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
      n_err++; $display("FAIL reset_flags: got vazia=%b cheia=%b nivel=%0d valido=%b, want 1 0 0 0", vazia, cheia, nivel, dado_valido);
    end
    n_cmp++; if ({ram_escrita, ram_end_saida, dado_out} !== 16'h0) begin
      n_err++; $display("FAIL reset_ram: got escrita=%b end_saida=%0d dado_out=%h, want 0", ram_escrita, ram_end_saida, dado_out);
    end
    rst_n = 1'b1;
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (dado_valido !== 1'b0 || nivel !== 6'd0) begin
        n_err++; $display("FAIL read_empty: got valido=%b nivel=%0d, want 0 0", dado_valido, nivel);
      end
    end
  endtask

  task automatic test_order();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; dado_in = vals[i];
      tick();
      n_cmp++; if (ram_escrita !== 1'b1 || ram_entrada !== vals[i] || ram_end_entrada !== 7'(i)) begin
        n_err++; $display("FAIL write_port%0d: got escrita=%b data=%h addr=%0d, want 1 %h %0d", i, ram_escrita, ram_entrada, ram_end_entrada, vals[i], i);
      end
    end
    wr_en = 1'b0;
    n_cmp++; if (nivel !== 6'd3 || vazia !== 1'b0) begin
      n_err++; $display("FAIL order_level: got nivel=%0d vazia=%b, want 3 0", nivel, vazia);
    end
    for (int i = 0; i < 6; i++) begin
      rd_req = (i < 3);
      tick();
      n_cmp++; if (dado_valido !== (i >= 2 && i <= 4)) begin
        n_err++; $display("FAIL order_valid%0d: got %b, want %b", i, dado_valido, (i >= 2 && i <= 4));
      end
      if (i >= 2 && i <= 4) begin
        n_cmp++; if (dado_out !== vals[i-2]) begin
          n_err++; $display("FAIL order_data%0d: got %h, want %h", i-2, dado_out, vals[i-2]);
        end
      end
    end
    n_cmp++; if (vazia !== 1'b1 || nivel !== 6'd0) begin
      n_err++; $display("FAIL order_empty: got vazia=%b nivel=%0d, want 1 0", vazia, nivel);
    end
  endtask

  task automatic test_raw();
    wr_en = 1'b1; dado_in = 8'hA5;
    tick();
    wr_en = 1'b0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    n_cmp++; if (dado_valido !== 1'b0) begin
      n_err++; $display("FAIL raw_early: got valido=%b, want 0", dado_valido);
    end
    tick();
    n_cmp++; if (dado_valido !== 1'b1 || dado_out !== 8'hA5) begin
      n_err++; $display("FAIL raw_data: got valido=%b data=%h, want 1 a5", dado_valido, dado_out);
    end
    tick();
    n_cmp++; if (dado_valido !== 1'b0) begin
      n_err++; $display("FAIL raw_pulse: got valido=%b, want 0", dado_valido);
    end
  endtask

  task automatic test_full();
    int k = 0;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; dado_in = 8'(i);
      tick();
    end
    n_cmp++; if (cheia !== 1'b1 || nivel !== 6'd32) begin
      n_err++; $display("FAIL full_flags: got cheia=%b nivel=%0d, want 1 32", cheia, nivel);
    end
    dado_in = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (ram_escrita !== 1'b0 || nivel !== 6'd32) begin
      n_err++; $display("FAIL full_drop: got escrita=%b nivel=%0d, want 0 32", ram_escrita, nivel);
    end
    for (int i = 0; i < 34; i++) begin
      rd_req = (i < 32);
      tick();
      if (dado_valido) begin
        n_cmp++; if (dado_out !== 8'(k)) begin
          n_err++; $display("FAIL full_drain%0d: got %h, want %h", k, dado_out, 8'(k));
        end
        k++;
      end
    end
    rd_req = 1'b0;
    n_cmp++; if (k !== 32 || vazia !== 1'b1) begin
      n_err++; $display("FAIL full_count: got %0d words vazia=%b, want 32 1", k, vazia);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int stable_err = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; dado_in = 8'h40 + 8'(i);
      tick();
    end
    n_cmp++; if (nivel !== 6'd5) begin
      n_err++; $display("FAIL b2b_fill: got nivel=%0d, want 5", nivel);
    end
    for (int i = 0; i < 47; i++) begin
      wr_en  = (i < 40);
      rd_req = 1'b1;
      dado_in = 8'h45 + 8'(i);
      tick();
      if (i < 40 && nivel !== 6'd5) stable_err++;
      if (dado_valido) begin
        n_cmp++; if (dado_out !== 8'h40 + 8'(k)) begin
          n_err++; $display("FAIL b2b_data%0d: got %h, want %h", k, dado_out, 8'h40 + 8'(k));
        end
        k++;
      end
    end
    wr_en = 1'b0; rd_req = 1'b0;
    tick(); tick();
    if (dado_valido) k++;
    n_cmp++; if (stable_err !== 0) begin
      n_err++; $display("FAIL b2b_level: got %0d cycles with nivel!=5, want 0", stable_err);
    end
    n_cmp++; if (k !== 45 || vazia !== 1'b1) begin
      n_err++; $display("FAIL b2b_count: got %0d words vazia=%b, want 45 1", k, vazia);
    end
  endtask

  task automatic test_reset_mid();
`ifdef FILA_ERRO_FLAGS_EN
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; dado_in = 8'(i);
      tick();
    end
    tick();
    wr_en = 1'b0;
    n_cmp++; if (erro_cheia !== 1'b1 || erro_vazia !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got cheia_err=%b vazia_err=%b, want 1 1", erro_cheia, erro_vazia);
    end
`else
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; dado_in = 8'h70 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
`endif
    rd_req = 1'b1;
    tick(); tick();
    rd_req = 1'b0;
    tick();
    n_cmp++; if (dado_valido !== 1'b1) begin
      n_err++; $display("FAIL mid_prereq: got valido=%b, want 1", dado_valido);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({dado_valido, vazia, cheia, nivel, dado_out} !== {1'b0, 1'b1, 1'b0, 6'd0, 8'h00}) begin
      n_err++; $display("FAIL mid_reset: got valido=%b vazia=%b cheia=%b nivel=%0d data=%h, want 0 1 0 0 00", dado_valido, vazia, cheia, nivel, dado_out);
    end
`ifdef FILA_ERRO_FLAGS_EN
    n_cmp++; if (erro_cheia !== 1'b0 || erro_vazia !== 1'b0) begin
      n_err++; $display("FAIL err_clear: got %b %b, want 0 0", erro_cheia, erro_vazia);
    end
`endif
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (dado_valido !== 1'b0) begin
        n_err++; $display("FAIL mid_flush%0d: got valido=%b, want 0", i, dado_valido);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_raw();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
